// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: data width and FSM state encodings.
package dmem_arbiter_pkg;

    localparam int DATA_WID = 32;

    typedef enum logic [1:0] {
        DM_IDLE   = 2'd0,
        DM_ACCESS = 2'd1,
        DM_RESP   = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with the last_grant register; a lone requester wins immediately.
module dmem_arbiter_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    input  logic accept_port,
    output logic grant0,
    output logic grant1
);

    logic last_grant_q;
    logic last_grant_d;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant0       = valid0 & (~valid1 | last_grant_q);
        grant1       = valid1 & (~valid0 | ~last_grant_q);
        last_grant_d = accept ? accept_port : last_grant_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Sequences one memory transaction at a time from two requesters: IDLE -> ACCESS -> RESP.
// Strobes and responses are registered; errors never touch the memory.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W    = DATA_WID,
    parameter int MEM_DEPTH = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [DATA_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [DATA_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp_valid,
    output logic              rsp_port,
    output logic [DATA_W-1:0] rsp_valM,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'(MEM_DEPTH - 1);

    dm_state_e         state_q, state_d;
    logic              idle_q, idle_d;
    logic              port_q, port_d;
    logic              err_q, err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_port_q, rsp_port_d;
    logic [DATA_W-1:0] rsp_valm_q, rsp_valm_d;
    logic              rsp_err_q, rsp_err_d;

    logic              grant0, grant1;
    logic              hs0, hs1, hs;
    logic              sel_port, sel_read, sel_write, req_err;
    logic [DATA_W-1:0] sel_addr, sel_wdata;

    dmem_arbiter_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .accept      (hs),
        .accept_port (sel_port),
        .grant0      (grant0),
        .grant1      (grant1)
    );

    // Handshake rule: a request is taken on the rising edge where reqX_valid & reqX_ready.
    // idle_q is a registered copy of "in IDLE" that stays low through reset, so ready is
    // never offered while rst_n is asserted.
    assign req0_ready = idle_q & grant0;
    assign req1_ready = idle_q & grant1;

    always_comb begin
        hs0       = req0_valid & req0_ready;
        hs1       = req1_valid & req1_ready;
        hs        = hs0 | hs1;
        sel_port  = hs1;
        sel_read  = hs1 ? req1_read  : req0_read;
        sel_write = hs1 ? req1_write : req0_write;
        sel_addr  = hs1 ? req1_addr  : req0_addr;
        sel_wdata = hs1 ? req1_wdata : req0_wdata;
        // Unsigned full-width compare: an all-ones address is out of range, not a wrap.
        req_err   = (sel_addr > MAX_ADDR) | (sel_read & sel_write);
    end

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        err_d       = err_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        rsp_valid_d = 1'b0;
        rsp_port_d  = 1'b0;
        rsp_valm_d  = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            DM_IDLE: begin
                if (hs) begin
                    state_d     = DM_ACCESS;
                    port_d      = sel_port;
                    err_d       = req_err;
                    // Strobes are registered, so they are decided here and live for ACCESS only.
                    mem_read_d  = sel_read & ~req_err;
                    mem_write_d = sel_write & ~req_err;
                    if ((sel_read | sel_write) & ~req_err) begin
                        mem_addr_d = sel_addr;
                    end
                    if (sel_write & ~req_err) begin
                        mem_wdata_d = sel_wdata;
                    end
                end
            end
            DM_ACCESS: begin
                state_d     = DM_RESP;
                rsp_valid_d = 1'b1;
                rsp_port_d  = port_q;
                rsp_err_d   = err_q;
                rsp_valm_d  = mem_read_q ? mem_rdata : '0;
            end
            DM_RESP: begin
                state_d = DM_IDLE;
            end
            default: begin
                state_d = DM_IDLE;
            end
        endcase
        idle_d = (state_d == DM_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DM_IDLE;
            idle_q      <= 1'b0;
            port_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_valm_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            port_q      <= port_d;
            err_q       <= err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
            rsp_valm_q  <= rsp_valm_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_port  = rsp_port_q;
    assign rsp_valM  = rsp_valm_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic on both ports, checked
// against a transaction-level model (round-robin grant, range/conflict errors, word memory).
module tb_dmem_arbiter;

    localparam int DEPTH = 11;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_read, req0_write;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_read, req1_write;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp_valid, rsp_port, rsp_err;
    logic [31:0] rsp_valM;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    req_t        q0[$];
    req_t        q1[$];
    int          m_last = 1;
    logic [31:0] ref_mem [0:15];
    logic [31:0] dev_mem [0:15];
    logic        dev_init = 1'b0;

    dmem_arbiter #(.DATA_W(32), .MEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_read  (req0_read),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_read  (req1_read),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_port   (rsp_port),
        .rsp_valM   (rsp_valM),
        .rsp_err    (rsp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 ^ (i * 32'h0101_0101);
    endfunction

    // Memory device: combinational read during a read strobe, write on the clock edge.
    assign mem_rdata = (mem_read && mem_addr < 32'd16) ? dev_mem[mem_addr[3:0]] : 32'h0;

    always @(posedge clk) begin
        if (!dev_init) begin
            for (int i = 0; i < 16; i++) dev_mem[i] <= init_word(i);
            dev_init <= 1'b1;
        end else if (mem_write && mem_addr < 32'd16) begin
            dev_mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver: present the head of each port queue, or drop valid when empty.
    task automatic drive_ports();
        if (q0.size() != 0) begin
            req0_valid = 1'b1; req0_read = q0[0].rd; req0_write = q0[0].wr;
            req0_addr = q0[0].addr; req0_wdata = q0[0].wdata;
        end else begin
            req0_valid = 1'b0;
        end
        if (q1.size() != 0) begin
            req1_valid = 1'b1; req1_read = q1[0].rd; req1_write = q1[0].wr;
            req1_addr = q1[0].addr; req1_wdata = q1[0].wdata;
        end else begin
            req1_valid = 1'b0;
        end
    endtask

    function automatic req_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d;
        return r;
    endfunction

    // One transaction: wait for a grant, then check the ACCESS and RESP cycles against the model.
    task automatic step(input bit b2b);
        int   g;
        int   exp_g;
        req_t r;
        logic err, e_rs, e_ws;
        logic [31:0] e_val;
        drive_ports();
        if (q0.size() != 0 && q1.size() != 0) exp_g = 1 - m_last;
        else exp_g = (q1.size() != 0) ? 1 : 0;
        g = -1;
        for (int i = 0; i < 12 && g < 0; i++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) g = 2;
            else if (req0_ready) g = 0;
            else if (req1_ready) g = 1;
            if (b2b && i == 0) check("back_to_back_ready", 32'(g >= 0), 32'd1);
        end
        if (g < 0) begin
            check("handshake_timeout", 32'd0, 32'd1);
            q0.delete(); q1.delete();
            return;
        end
        check("grant_port", 32'(g), 32'(exp_g));
        if (g == 2) g = exp_g;
        r = (g == 0) ? q0[0] : q1[0];
        @(posedge clk);
        m_last = g;
        if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        err   = (r.addr >= 32'(DEPTH)) || (r.rd && r.wr);
        e_rs  = !err && r.rd;
        e_ws  = !err && r.wr;
        e_val = e_rs ? ref_mem[r.addr[3:0]] : 32'h0;
        if (e_ws) ref_mem[r.addr[3:0]] = r.wdata;
        @(negedge clk);
        check("access_mem_read", 32'(mem_read), 32'(e_rs));
        check("access_mem_write", 32'(mem_write), 32'(e_ws));
        if (e_rs || e_ws) check("access_mem_addr", mem_addr, r.addr);
        if (e_ws) check("access_mem_wdata", mem_wdata, r.wdata);
        check("access_rsp_valid", 32'(rsp_valid), 32'd0);
        check("access_state", 32'(dbg_state), 32'd1);
        drive_ports();
        check("access_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clk);
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_port", 32'(rsp_port), 32'(g));
        check("resp_valM", rsp_valM, e_val);
        check("resp_err", 32'(rsp_err), 32'(err));
        check("resp_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("resp_ready", 32'({req1_ready, req0_ready}), 32'd0);
    endtask

    task automatic run_all();
        bit first = 1'b1;
        while (q0.size() + q1.size() > 0) begin
            step(!first);
            first = 1'b0;
        end
        drive_ports();
    endtask

    initial begin
        int   found;
        int   k;
        req_t r;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

        // Reset held with both ports requesting
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_read = 1'b1; req0_write = 1'b0;
        req0_addr = 32'd1; req0_wdata = $urandom;
        req1_valid = 1'b1; req1_read = 1'b0; req1_write = 1'b1;
        req1_addr = 32'd2; req1_wdata = $urandom;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'({req1_ready, req0_ready}), 32'd0);
        check("reset_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Both ports continuously valid: grants alternate starting with port 0
        q0.push_back(mk(1'b1, 1'b0, 32'd0, 32'h0));
        q0.push_back(mk(1'b1, 1'b0, 32'd1, 32'h0));
        q1.push_back(mk(1'b1, 1'b0, 32'd5, 32'h0));
        q1.push_back(mk(1'b1, 1'b0, 32'd10, 32'h0));
        run_all();

        // Port 0 write then read-back
        q0.push_back(mk(1'b0, 1'b1, 32'd3, 32'h0000_DEAD));
        q0.push_back(mk(1'b1, 1'b0, 32'd3, 32'h0));
        run_all();

        // Out-of-range, conflict, no-op and all-ones address
        q1.push_back(mk(1'b1, 1'b0, 32'd11, 32'h0));
        q1.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678));
        run_all();
        q0.push_back(mk(1'b1, 1'b1, 32'd2, 32'hBAD0_BAD0));
        q0.push_back(mk(1'b1, 1'b0, 32'd2, 32'h0));
        q0.push_back(mk(1'b0, 1'b0, 32'd4, 32'h5555_5555));
        run_all();

        // Reset asserted during the ACCESS cycle of a port 0 write
        q0.push_back(mk(1'b0, 1'b1, 32'd4, 32'hCAFE_F00D));
        drive_ports();
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            @(negedge clk);
            if (req0_ready) found = 1;
        end
        check("midreset_handshake", 32'(found), 32'd1);
        @(posedge clk);
        void'(q0.pop_front());
        @(negedge clk);
        check("midreset_write_before", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_write_dropped", 32'(mem_write), 32'd0);
        req0_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midreset_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        m_last = 1;
        q1.push_back(mk(1'b1, 1'b0, 32'd4, 32'h0));
        q0.push_back(mk(1'b1, 1'b0, 32'd4, 32'h0));
        run_all();

        // Random traffic on both ports
        for (int n = 0; n < 48; n++) begin
            k = $urandom_range(0, 9);
            r.rd = (k <= 3) || (k == 8);
            r.wr = (k >= 4 && k <= 8);
            r.addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
            r.wdata = $urandom;
            if ($urandom_range(0, 1) == 0) q0.push_back(r); else q1.push_back(r);
            if (n % 8 == 7) run_all();
        end
        run_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
